uart_result_sender: RTL and testbench
=====================================

// Module: uart_result_sender
// PURPOSE
//  Sequences the shared byte-wide UART transmitter to echo a calculator result back to the host.
//  On a send request it latches a BCD value and emits it as ASCII text followed by an end-of-line,
//  one byte per transmitter handshake. It sits between the calculator display register and uart_tx.
// PARAMETERS
//  DIGITS    4  number of BCD nibbles in value (1..8)
//  EOL_CRLF  1  1: line ends "\r\n" (0x0D,0x0A); 0: line ends "\n" only
// PORTS
//  clk       in   1           system clock
//  rst       in   1           synchronous, active-high reset
//  send      in   1           one-cycle request; honoured only while busy=0
//  value     in   4*DIGITS    BCD result, MS nibble first; sampled in the cycle send=1
//  tx_busy   in   1           uart_tx busy flag; high while a byte is in flight
//  tx_start  out  1           one-cycle strobe to uart_tx; tx_data valid in same cycle
//  tx_data   out  8           ASCII byte for uart_tx
//  busy      out  1           high from the cycle after an accepted send until done
//  done      out  1           one-cycle pulse after the last byte's tx_busy falls
// BEHAVIOUR
//  Reset: the only clock is clk; reset is synchronous and active-high. All outputs 0,
//   state IDLE, latched value cleared.
//  States: IDLE -> LOAD -> ISSUE -> ACK -> DRAIN -> (ISSUE | FINISH) -> IDLE.
//   IDLE:   send=1 -> latch value, go LOAD; busy=1 next cycle. send while busy=1 is dropped.
//   LOAD:   build byte queue (see formatting), ptr=0; go ISSUE.
//   ISSUE:  wait tx_busy=0, then tx_start=1 for exactly one cycle with tx_data=queue[ptr]; go ACK.
//   ACK:    wait tx_busy=1 (uart_tx raises it the cycle after tx_start); go DRAIN.
//   DRAIN:  wait tx_busy=0; ptr+1; ptr==len -> FINISH, else ISSUE.
//   FINISH: done=1 one cycle, busy=0 same cycle; go IDLE.
//  Formatting (fixed at LOAD from latched value):
//   - any nibble >9 -> text "ERR" (0x45,0x52,0x52) replaces all digits
//   - else digit d -> 8'h30+d; leading zero nibbles suppressed, the LS digit always sent
//   - EOL appended per EOL_CRLF; len = digit/ERR count + 1 or 2, max DIGITS+2
//  Latency: send -> first tx_start = 3 cycles when tx_busy=0 (IDLE, LOAD, ISSUE).
//  tx_data holds its value between strobes; only sampled on tx_start.
//  No back-to-back strobes: at least one ACK+DRAIN round between any two tx_start.
//  Edge cases:
//   - tx_busy already 1 at ISSUE: hold, no strobe until it falls.
//   - send in the FINISH cycle: ignored (busy still asserted at that edge).
//   - value changes after latch: no effect on the frame in progress.
//   - rst mid-frame: next edge tx_start=0, busy=0, done not pulsed, remaining bytes discarded.
//  No timeout: a uart_tx that never raises tx_busy stalls in ACK until rst.
// STRUCTURE
//  Shared package calc_pkg: ASCII constants (ASC_0, ASC_CR, ASC_LF, ASC_E, ASC_R), state encoding
//   for this FSM (one-hot, matching the calculator FSM style).
//  Sub-module result_formatter: combinational value -> byte queue + len, instantiated once;
//   sequencing FSM and pointer stay in uart_result_sender.
// TESTING (bench models uart_tx: tx_busy rises 1 cycle after tx_start, held 10 cycles)
//  1 value=16'h0123, send -> bytes 0x31,0x32,0x33,0x0D,0x0A; done pulses once; 5 strobes total.
//  2 value=16'h0000 -> bytes 0x30,0x0D,0x0A (single zero kept); EOL_CRLF=0 -> 0x30,0x0A.
//  3 value=16'h0FFF -> bytes 0x45,0x52,0x52,0x0D,0x0A.
//  4 send pulsed again mid-frame with 16'h0999 -> ignored; frame of first value unchanged.
//  5 tx_busy held high 20 cycles before send -> first tx_start only after tx_busy falls.
//  6 rst asserted after 2nd strobe -> tx_start/busy 0 next edge, no done; new send yields full frame.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: ASCII codes and
// one-hot state encoding for the result sender FSM.
package calc_pkg;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_R  = 8'h52;

  // byte count / pointer width, covers up to 8 digits + CRLF
  localparam int LEN_W = 4;

  localparam int S_IDLE   = 0;
  localparam int S_LOAD   = 1;
  localparam int S_ISSUE  = 2;
  localparam int S_ACK    = 3;
  localparam int S_DRAIN  = 4;
  localparam int S_FINISH = 5;

  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_LOAD   = 6'b000010;
  localparam logic [5:0] ST_ISSUE  = 6'b000100;
  localparam logic [5:0] ST_ACK    = 6'b001000;
  localparam logic [5:0] ST_DRAIN  = 6'b010000;
  localparam logic [5:0] ST_FINISH = 6'b100000;

endpackage

// File: rtl/result_formatter.sv
// BCD value to ASCII byte queue (first byte in the
// low byte) plus byte count, including end-of-line.
module result_formatter
  import calc_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic [4*DIGITS-1:0]     i_value,
  output logic [8*(DIGITS+2)-1:0] o_queue,
  output logic [LEN_W-1:0]        o_len
);

  localparam int QB = 8*(DIGITS+2);

  logic             w_err;
  logic             w_seen;
  logic [3:0]       w_nib;
  logic [LEN_W-1:0] w_n;
  logic [QB-1:0]    w_q;

  // Append digits (or ERR) then the line ending.
  always_comb begin
    w_err  = 1'b0;
    w_seen = 1'b0;
    w_nib  = 4'd0;
    w_n    = '0;
    w_q    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_value[4*i +: 4] > 4'd9) w_err = 1'b1;
    end
    if (w_err) begin
      w_q = QB'({ASC_R, ASC_R, ASC_E});
      w_n = LEN_W'(3);
    end else begin
      for (int i = DIGITS-1; i >= 0; i--) begin
        w_nib = i_value[4*i +: 4];
        // leading zeros dropped, LS digit always kept
        if (w_nib != 4'd0 || i == 0) w_seen = 1'b1;
        if (w_seen) begin
          w_q = w_q |
            (QB'(ASC_0 + {4'd0, w_nib}) << {w_n, 3'b000});
          w_n = w_n + LEN_W'(1);
        end
      end
    end
    if (EOL_CRLF) begin
      w_q = w_q | (QB'(ASC_CR) << {w_n, 3'b000});
      w_n = w_n + LEN_W'(1);
    end
    w_q = w_q | (QB'(ASC_LF) << {w_n, 3'b000});
    w_n = w_n + LEN_W'(1);
    o_queue = w_q;
    o_len   = w_n;
  end

endmodule

// File: rtl/uart_result_sender.sv
// Streams a latched BCD result as ASCII text plus
// end-of-line through a byte-wide uart_tx handshake.
module uart_result_sender
  import calc_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                send,
  input  logic [4*DIGITS-1:0] value,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                done
);

  localparam int QB = 8*(DIGITS+2);

  logic [5:0]          r_state;
  logic [4*DIGITS-1:0] r_value;
  logic [QB-1:0]       r_queue;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_ptr;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic                r_busy;
  logic                r_done;

  logic [QB-1:0]       w_queue;
  logic [LEN_W-1:0]    w_len;
  logic [7:0]          w_byte;

  result_formatter #(
    .DIGITS   (DIGITS),
    .EOL_CRLF (EOL_CRLF)
  ) u_fmt (
    .i_value (r_value),
    .o_queue (w_queue),
    .o_len   (w_len)
  );

  assign w_byte = 8'(r_queue >> {r_ptr, 3'b000});

  // Sequencing FSM: one byte per tx handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_value    <= '0;
      r_queue    <= '0;
      r_len      <= '0;
      r_ptr      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      unique case (1'b1)
        r_state[S_IDLE]: begin
          if (send) begin
            r_value <= value;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        r_state[S_LOAD]: begin
          r_queue <= w_queue;
          r_len   <= w_len;
          r_ptr   <= '0;
          r_state <= ST_ISSUE;
        end
        r_state[S_ISSUE]: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_state    <= ST_ACK;
          end
        end
        r_state[S_ACK]: begin
          if (tx_busy) r_state <= ST_DRAIN;
        end
        r_state[S_DRAIN]: begin
          if (!tx_busy) begin
            r_ptr <= r_ptr + LEN_W'(1);
            if (r_ptr + LEN_W'(1) == r_len)
              r_state <= ST_FINISH;
            else
              r_state <= ST_ISSUE;
          end
        end
        r_state[S_FINISH]: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_result_sender.sv
// Bench for uart_result_sender with a uart_tx model:
// busy rises the cycle after tx_start, held 10 cycles.
module tb_uart_result_sender;

  logic        clk;
  logic        rst;
  logic        send0, send1;
  logic [15:0] value0, value1;
  logic        tx_busy0, tx_busy1;
  logic        tx_start0, tx_start1;
  logic [7:0]  tx_data0, tx_data1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic        ext_busy;

  int cnt0, cnt1;
  int stb0, stb1;
  int dcnt0, dcnt1;
  int viol0, viol1;
  logic [7:0] log0[$];
  logic [7:0] log1[$];

  int checks;
  int errors;

  typedef struct {
    int          sel;
    logic [15:0] v;
    int          n;
    logic [47:0] b;
    string       nm;
  } vec_t;

  vec_t tv[11];

  uart_result_sender #(.DIGITS(4), .EOL_CRLF(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send0),
    .value    (value0),
    .tx_busy  (tx_busy0),
    .tx_start (tx_start0),
    .tx_data  (tx_data0),
    .busy     (busy0),
    .done     (done0)
  );

  uart_result_sender #(.DIGITS(4), .EOL_CRLF(1'b0)) dut_lf (
    .clk      (clk),
    .rst      (rst),
    .send     (send1),
    .value    (value1),
    .tx_busy  (tx_busy1),
    .tx_start (tx_start1),
    .tx_data  (tx_data1),
    .busy     (busy1),
    .done     (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy0 = (cnt0 != 0) | ext_busy;
  assign tx_busy1 = (cnt1 != 0);

  always @(posedge clk) begin
    if (tx_start0) begin
      if (tx_busy0) viol0++;
      cnt0 <= 10;
      log0.push_back(tx_data0);
      stb0++;
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
    end
    if (done0) begin
      dcnt0++;
      if (busy0) viol0++;
    end
  end

  always @(posedge clk) begin
    if (tx_start1) begin
      if (tx_busy1) viol1++;
      cnt1 <= 10;
      log1.push_back(tx_data1);
      stb1++;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
    end
    if (done1) begin
      dcnt1++;
      if (busy1) viol1++;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int sel, input int d0,
                           input string nm);
    int k;
    k = 0;
    while (((sel == 0) ? dcnt0 : dcnt1) == d0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, 64'(k < 400), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_frame(input int sel, input string nm,
                           input int n, input logic [47:0] b,
                           input int d0);
    logic [7:0] q[$];
    int d;
    if (sel == 0) begin
      q = log0;
      d = dcnt0;
    end else begin
      q = log1;
      d = dcnt1;
    end
    chk({nm, "_len"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk({nm, "_byte"},
          64'((i < q.size()) ? q[i] : 8'h00),
          64'(b[47-8*i -: 8]));
    end
    chk({nm, "_done"}, 64'(d - d0), 64'd1);
  endtask

  task automatic start_send(input int sel, input logic [15:0] v);
    @(negedge clk);
    if (sel == 0) begin
      log0.delete();
      value0 = v;
      send0  = 1'b1;
    end else begin
      log1.delete();
      value1 = v;
      send1  = 1'b1;
    end
    @(negedge clk);
    send0 = 1'b0;
    send1 = 1'b0;
  endtask

  task automatic run_vec(input vec_t t);
    int d0;
    d0 = (t.sel == 0) ? dcnt0 : dcnt1;
    start_send(t.sel, t.v);
    wait_done(t.sel, d0, t.nm);
    chk_frame(t.sel, t.nm, t.n, t.b, d0);
  endtask

  initial begin
    int d0, s0, k;
    checks = 0; errors = 0;
    cnt0 = 0; cnt1 = 0; stb0 = 0; stb1 = 0;
    dcnt0 = 0; dcnt1 = 0; viol0 = 0; viol1 = 0;
    rst = 1'b1; ext_busy = 1'b0;
    send0 = 1'b0; send1 = 1'b0;
    value0 = 16'h0; value1 = 16'h0;

    tv[0]  = '{0, 16'h0123, 5, 48'h3132330D0A00, "v0123"};
    tv[1]  = '{0, 16'h0000, 3, 48'h300D0A000000, "v0000"};
    tv[2]  = '{0, 16'h0FFF, 5, 48'h4552520D0A00, "v0FFF"};
    tv[3]  = '{0, 16'h9999, 6, 48'h393939390D0A, "v9999"};
    tv[4]  = '{0, 16'h0A00, 5, 48'h4552520D0A00, "v0A00"};
    tv[5]  = '{0, 16'h1000, 6, 48'h313030300D0A, "v1000"};
    tv[6]  = '{0, 16'h0005, 3, 48'h350D0A000000, "v0005"};
    tv[7]  = '{0, 16'h0090, 4, 48'h39300D0A0000, "v0090"};
    tv[8]  = '{1, 16'h0000, 2, 48'h300A00000000, "lf0000"};
    tv[9]  = '{1, 16'h0120, 4, 48'h3132300A0000, "lf0120"};
    tv[10] = '{1, 16'hF000, 4, 48'h4552520A0000, "lfF000"};

    repeat (3) @(negedge clk);
    chk("rst_tx_start", 64'(tx_start0), 64'd0);
    chk("rst_tx_data", 64'(tx_data0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // first frame with latency measurement
    d0 = dcnt0;
    log0.delete();
    value0 = 16'h0123;
    send0 = 1'b1;
    k = 0;
    while (!tx_start0 && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        send0 = 1'b0;
        chk("busy_after_send", 64'(busy0), 64'd1);
      end
    end
    chk("latency", 64'(k), 64'd3);
    wait_done(0, d0, "lat");
    chk_frame(0, "lat", 5, 48'h3132330D0A00, d0);
    chk("busy_after_done", 64'(busy0), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(tv[i]);

    // send mid-frame is dropped
    d0 = dcnt0;
    start_send(0, 16'h0123);
    repeat (15) @(negedge clk);
    value0 = 16'h0999;
    send0 = 1'b1;
    @(negedge clk);
    send0 = 1'b0;
    wait_done(0, d0, "midsend");
    chk_frame(0, "midsend", 5, 48'h3132330D0A00, d0);
    repeat (30) @(negedge clk);
    chk("midsend_no_2nd", 64'(dcnt0 - d0), 64'd1);
    chk("midsend_idle", 64'(busy0), 64'd0);

    // tx_busy held high before send
    ext_busy = 1'b1;
    repeat (20) @(negedge clk);
    d0 = dcnt0;
    s0 = stb0;
    start_send(0, 16'h0042);
    repeat (15) @(negedge clk);
    chk("held_no_strobe", 64'(stb0 - s0), 64'd0);
    ext_busy = 1'b0;
    wait_done(0, d0, "held");
    chk_frame(0, "held", 4, 48'h34320D0A0000, d0);

    // reset after second strobe
    d0 = dcnt0;
    s0 = stb0;
    start_send(0, 16'h0123);
    k = 0;
    while (stb0 < s0 + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_reach", 64'(k < 200), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_start", 64'(tx_start0), 64'd0);
    chk("rst_mid_busy", 64'(busy0), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_done", 64'(dcnt0 - d0), 64'd0);
    chk("rst_mid_strobes", 64'(stb0 - s0), 64'd2);
    run_vec(tv[0]);

    chk("protocol0", 64'(viol0), 64'd0);
    chk("protocol1", 64'(viol1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
